// File: rtl/rv_mc_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit and its ALU decoder.
package rv_mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR,
      S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_UPPER, S_TRAP
   } state_t;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLTU = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9
   } alu_op_t;

   // Which family of ALU operation the current state asks the decoder for.
   typedef enum logic [1:0] {CLS_ADD, CLS_SUB, CLS_R, CLS_I} alu_class_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_J = 3'd3;
   localparam logic [2:0] IMM_U = 3'd4;

   localparam logic [1:0] RES_ALUOUT  = 2'd0;
   localparam logic [1:0] RES_MEMDATA = 2'd1;
   localparam logic [1:0] RES_ALU     = 2'd2;

   localparam logic [1:0] SRCA_PC    = 2'd0;
   localparam logic [1:0] SRCA_OLDPC = 2'd1;
   localparam logic [1:0] SRCA_RS1   = 2'd2;

   localparam logic [1:0] SRCB_RS2  = 2'd0;
   localparam logic [1:0] SRCB_IMM  = 2'd1;
   localparam logic [1:0] SRCB_FOUR = 2'd2;

   localparam logic [1:0] FAULT_NONE    = 2'd0;
   localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
   localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

   // Branch condition from funct3 and the ALU flags; reserved encodings never take.
   function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                         input logic lt, input logic ltu);
      case (funct3)
         3'b000:  return zero;
         3'b001:  return !zero;
         3'b100:  return lt;
         3'b101:  return !lt;
         3'b110:  return ltu;
         3'b111:  return !ltu;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_alu_dec.sv
// ALU operation decoder: operation class plus funct3/funct7b5 to an alu_op_t.
module rv_alu_dec
   import rv_mc_pkg::*;
(
   input  alu_class_t  alu_class,
   input  logic [2:0]  funct3,
   input  logic        funct7b5,
   output alu_op_t     alu_op
);

   // NOTE: every output gets a default before the case, so no path can infer a latch.
   always_comb begin
      alu_op = ALU_ADD;
      case (alu_class)
         CLS_ADD: alu_op = ALU_ADD;
         CLS_SUB: alu_op = ALU_SUB;
         CLS_R, CLS_I: begin
            case (funct3)
               // Immediate forms have no SUB; bit 30 is part of the immediate there.
               3'b000:  alu_op = (alu_class == CLS_R && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_op = ALU_SLL;
               3'b010:  alu_op = ALU_SLT;
               3'b011:  alu_op = ALU_SLTU;
               3'b100:  alu_op = ALU_XOR;
               3'b101:  alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
               3'b110:  alu_op = ALU_OR;
               default: alu_op = ALU_AND;
            endcase
         end
         default: alu_op = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multicycle RV32I control FSM with mem_req/mem_ready handshake and per-access timeout.
// Define RV_MC_UPPER_IMM_EN to decode LUI/AUIPC through the UPPER state; otherwise they trap as illegal.
module rv_multicycle_ctrl
   import rv_mc_pkg::*;
#(
   parameter int ALUCTRL_W   = 4,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [6:0]           op,
   input  logic [2:0]           funct3,
   input  logic                 funct7b5,
   input  logic                 zero,
   input  logic                 lt,
   input  logic                 ltu,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 adr_src,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic                 reg_write,
   output logic [1:0]           alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [2:0]           imm_src,
   output logic [1:0]           result_src,
   output logic [ALUCTRL_W-1:0] alu_control,
   output logic                 fault,
   output logic [1:0]           fault_code
);

   state_t     state, state_nxt;
   logic [7:0] wait_cnt, wait_cnt_nxt;
   logic [1:0] fault_code_r, trap_code;
   logic       mem_wait, timeout, taken;
   alu_class_t alu_class;
   alu_op_t    alu_op;

   rv_alu_dec u_alu_dec (
      .alu_class (alu_class),
      .funct3    (funct3),
      .funct7b5  (funct7b5),
      .alu_op    (alu_op)
   );

   // A wait cycle is any memory state still waiting; mem_ready in the limit cycle wins over the timeout.
   assign mem_wait     = (state == S_FETCH || state == S_MEMRD || state == S_MEMWR) && !mem_ready;
   assign timeout      = mem_wait && (wait_cnt == 8'(MEM_TIMEOUT - 1));
   assign wait_cnt_nxt = (mem_wait && !timeout) ? wait_cnt + 8'd1 : 8'd0;
   assign taken        = branch_taken(funct3, zero, lt, ltu);

   always_comb begin
      state_nxt = state;
      trap_code = FAULT_NONE;
      case (state)
         S_FETCH: begin
            if (mem_ready)    state_nxt = S_DECODE;
            else if (timeout) begin state_nxt = S_TRAP; trap_code = FAULT_TIMEOUT; end
         end
         S_DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
               OP_R:              state_nxt = S_EXECR;
               OP_I:              state_nxt = S_EXECI;
               OP_BRANCH:         state_nxt = S_BRANCH;
               OP_JAL:            state_nxt = S_JAL;
`ifdef RV_MC_UPPER_IMM_EN
               OP_LUI, OP_AUIPC:  state_nxt = S_UPPER;
`endif
               default: begin state_nxt = S_TRAP; trap_code = FAULT_ILLEGAL; end
            endcase
         end
         S_MEMADR: state_nxt = (op == OP_STORE) ? S_MEMWR : S_MEMRD;
         S_MEMRD: begin
            if (mem_ready)    state_nxt = S_MEMWB;
            else if (timeout) begin state_nxt = S_TRAP; trap_code = FAULT_TIMEOUT; end
         end
         S_MEMWR: begin
            if (mem_ready)    state_nxt = S_FETCH;
            else if (timeout) begin state_nxt = S_TRAP; trap_code = FAULT_TIMEOUT; end
         end
         S_EXECR, S_EXECI, S_UPPER: state_nxt = S_ALUWB;
         S_BRANCH: begin
            if (funct3 == 3'b010 || funct3 == 3'b011) begin
               state_nxt = S_TRAP;
               trap_code = FAULT_ILLEGAL;
            end else begin
               state_nxt = S_FETCH;
            end
         end
         S_MEMWB, S_ALUWB, S_JAL: state_nxt = S_FETCH;
         S_TRAP:                  state_nxt = S_TRAP;
         default:                 begin state_nxt = S_TRAP; trap_code = FAULT_ILLEGAL; end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on the clock edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_FETCH;
         wait_cnt     <= 8'd0;
         fault_code_r <= FAULT_NONE;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (state != S_TRAP && state_nxt == S_TRAP) fault_code_r <= trap_code;
      end
   end

   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      imm_src    = IMM_I;
      result_src = RES_ALUOUT;
      alu_class  = CLS_ADD;
      case (state)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALU;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            imm_src   = IMM_B;
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
         end
         S_MEMWB: begin
            result_src = RES_MEMDATA;
            reg_write  = 1'b1;
         end
         S_MEMWR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            adr_src = 1'b1;
         end
         S_EXECR: begin
            alu_src_a = SRCA_RS1;
            alu_class = CLS_R;
         end
         S_EXECI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_class = CLS_I;
         end
         S_ALUWB: reg_write = 1'b1;
         S_BRANCH: begin
            alu_src_a = SRCA_RS1;
            alu_class = CLS_SUB;
            pc_write  = taken;
         end
         S_JAL: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            imm_src   = IMM_J;
            pc_write  = 1'b1;
            reg_write = 1'b1;
         end
         S_UPPER: begin
            // LUI relies on the datapath forcing rs1 to x0.
            alu_src_a = (op == OP_AUIPC) ? SRCA_OLDPC : SRCA_RS1;
            alu_src_b = SRCB_IMM;
            imm_src   = IMM_U;
         end
         default: ;
      endcase
      // Strobes must be quiet during reset, whatever state the register still holds.
      if (rst) begin
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         ir_write  = 1'b0;
         pc_write  = 1'b0;
         reg_write = 1'b0;
      end
   end

   assign alu_control = ALUCTRL_W'(alu_op);
   assign fault       = (state == S_TRAP);
   assign fault_code  = fault_code_r;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Table-driven bench for rv_multicycle_ctrl: one row per clock, masked compare of all outputs.
module tb_rv_multicycle_ctrl;

   localparam logic [6:0] T_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] T_OP_STORE  = 7'b0100011;
   localparam logic [6:0] T_OP_R      = 7'b0110011;
   localparam logic [6:0] T_OP_I      = 7'b0010011;
   localparam logic [6:0] T_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] T_OP_JAL    = 7'b1101111;
   localparam logic [6:0] T_OP_LUI    = 7'b0110111;
   localparam logic [6:0] T_OP_AUIPC  = 7'b0010111;

   typedef enum {T_RST, T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR,
                 T_EXECR, T_EXECI, T_ALUWB, T_BRANCH, T_JAL, T_UPPER, T_TRAP} tstate_e;

   typedef struct packed {
      logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, fault;
      logic [1:0] fault_code, a, b;
      logic [2:0] imm;
      logic [1:0] res;
      logic [3:0] alu;
   } out_t;

   typedef struct {
      logic       rst;
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      logic [2:0] flags;   // {zero, lt, ltu}
      logic       rdy;
      tstate_e    st;
      logic       irw, pcw;
      logic [3:0] alu;
      logic [1:0] a;
      logic [2:0] imm;
      logic [1:0] fc;
   } vec_t;

   logic clk = 1'b0, rst = 1'b1;
   logic [6:0] op = '0;
   logic [2:0] funct3 = '0;
   logic funct7b5 = 1'b0, zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;
   logic mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, fault;
   logic [1:0] alu_src_a, alu_src_b, result_src, fault_code;
   logic [2:0] imm_src;
   logic [3:0] alu_control;

   vec_t rows[$];
   logic [6:0] cur_op;
   logic [2:0] cur_f3, cur_flags;
   logic       cur_f7;
   int n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   rv_multicycle_ctrl #(.ALUCTRL_W(4), .MEM_TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
      .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .imm_src(imm_src), .result_src(result_src),
      .alu_control(alu_control), .fault(fault), .fault_code(fault_code)
   );

   task automatic ir(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic [2:0] fl);
      cur_op = o; cur_f3 = f3; cur_f7 = f7; cur_flags = fl;
   endtask

   task automatic push(input logic r, input logic rdy, input tstate_e st,
                       input logic irw = 1'b0, input logic pcw = 1'b0,
                       input logic [3:0] alu = 4'd0, input logic [1:0] a = 2'd0,
                       input logic [2:0] imm = 3'd0, input logic [1:0] fc = 2'd0);
      vec_t v;
      v.rst = r; v.op = cur_op; v.f3 = cur_f3; v.f7 = cur_f7; v.flags = cur_flags; v.rdy = rdy;
      v.st = st; v.irw = irw; v.pcw = pcw; v.alu = alu; v.a = a; v.imm = imm; v.fc = fc;
      rows.push_back(v);
   endtask

   task automatic fetch_dec();
      push(0, 1, T_FETCH, 1, 1);
      push(0, 0, T_DECODE);
   endtask

   task automatic alu_seq(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic [3:0] alu);
      ir(o, f3, f7, 3'b000);
      fetch_dec();
      push(0, 0, (o == T_OP_R) ? T_EXECR : T_EXECI, 0, 0, alu);
      push(0, 0, T_ALUWB);
   endtask

   task automatic br(input logic [2:0] f3, input logic [2:0] fl, input logic tk);
      ir(T_OP_BRANCH, f3, 0, fl);
      fetch_dec();
      push(0, 0, T_BRANCH, 0, tk);
   endtask

   // Expected outputs and the mask of fields the row constrains, from the state each row names.
   function automatic void expect_of(input vec_t v, output out_t e, output out_t m);
      e = '0; m = '0;
      m.mem_req = 1; m.mem_we = 1; m.ir_write = 1; m.pc_write = 1; m.reg_write = 1;
      if (v.st != T_RST) begin m.fault = 1; m.fault_code = '1; e.fault_code = v.fc; end
      e.ir_write = v.irw; e.pc_write = v.pcw;
      case (v.st)
         T_FETCH:  begin e.mem_req = 1; e.b = 2; e.res = 2;
                         m.adr_src = 1; m.a = '1; m.b = '1; m.alu = '1; m.res = '1; end
         T_DECODE: begin e.a = 1; e.b = 1; e.imm = 2; m.a = '1; m.b = '1; m.imm = '1; m.alu = '1; end
         T_MEMADR: begin e.a = 2; e.b = 1; e.imm = v.imm; m.a = '1; m.b = '1; m.imm = '1; m.alu = '1; end
         T_MEMRD:  begin e.mem_req = 1; e.adr_src = 1; m.adr_src = 1; end
         T_MEMWB:  begin e.res = 1; e.reg_write = 1; m.res = '1; end
         T_MEMWR:  begin e.mem_req = 1; e.mem_we = 1; e.adr_src = 1; m.adr_src = 1; end
         T_EXECR:  begin e.a = 2; e.b = 0; e.alu = v.alu; m.a = '1; m.b = '1; m.alu = '1; end
         T_EXECI:  begin e.a = 2; e.b = 1; e.alu = v.alu; m.a = '1; m.b = '1; m.alu = '1; end
         T_ALUWB:  begin e.res = 0; e.reg_write = 1; m.res = '1; end
         T_BRANCH: begin e.a = 2; e.b = 0; e.alu = 1; e.res = 0;
                         m.a = '1; m.b = '1; m.alu = '1; m.res = '1; end
         T_JAL:    begin e.a = 1; e.b = 2; e.alu = 0; e.res = 0; e.imm = 3; e.reg_write = 1;
                         m.a = '1; m.b = '1; m.alu = '1; m.res = '1; m.imm = '1; end
         T_UPPER:  begin e.a = v.a; e.b = 1; e.imm = 4; e.alu = 0;
                         m.a = '1; m.b = '1; m.imm = '1; m.alu = '1; end
         T_TRAP:   e.fault = 1;
         default:  ;
      endcase
   endfunction

   task automatic check(input string name, input out_t act, input out_t exp, input out_t care);
      n_tests++;
      if (((act ^ exp) & care) !== '0) begin
         n_fail++;
         $display("FAIL %s: got %h want %h (mask %h)", name, act & care, exp & care, care);
      end
   endtask

   task automatic fill();
      ir(7'd0, 0, 0, 0);
      push(1, 0, T_RST);
      push(1, 0, T_RST);
      // addi x1,x0,5
      alu_seq(T_OP_I, 3'b000, 0, 4'd0);
      // ALU decode coverage
      alu_seq(T_OP_R, 3'b000, 1, 4'd1);   // sub
      alu_seq(T_OP_I, 3'b000, 1, 4'd0);   // addi with bit30 set stays ADD
      alu_seq(T_OP_I, 3'b101, 1, 4'd9);   // srai
      alu_seq(T_OP_R, 3'b101, 0, 4'd8);   // srl
      alu_seq(T_OP_R, 3'b011, 0, 4'd6);   // sltu
      alu_seq(T_OP_I, 3'b010, 0, 4'd5);   // slti
      alu_seq(T_OP_R, 3'b001, 0, 4'd7);   // sll
      alu_seq(T_OP_R, 3'b100, 0, 4'd4);   // xor
      alu_seq(T_OP_R, 3'b110, 0, 4'd3);   // or
      alu_seq(T_OP_R, 3'b111, 0, 4'd2);   // and
      // lw with three wait cycles in MEMRD: 8 cycles total
      ir(T_OP_LOAD, 3'b010, 0, 0);
      fetch_dec();
      push(0, 0, T_MEMADR, 0, 0, 0, 0, 3'd0);
      for (int i = 0; i < 3; i++) push(0, 0, T_MEMRD);
      push(0, 1, T_MEMRD);
      push(0, 0, T_MEMWB);
      // sw with two fetch wait cycles
      ir(T_OP_STORE, 3'b010, 0, 0);
      push(0, 0, T_FETCH);
      push(0, 0, T_FETCH);
      fetch_dec();
      push(0, 0, T_MEMADR, 0, 0, 0, 0, 3'd1);
      push(0, 1, T_MEMWR);
      // branches, flags {zero,lt,ltu}
      br(3'b000, 3'b100, 1);   // beq, zero
      br(3'b001, 3'b100, 0);   // bne, zero
      br(3'b100, 3'b010, 1);   // blt, lt
      br(3'b101, 3'b010, 0);   // bge, lt
      br(3'b110, 3'b001, 1);   // bltu, ltu
      br(3'b111, 3'b100, 1);   // bgeu, !ltu
      br(3'b111, 3'b001, 0);   // bgeu, ltu
      // jal
      ir(T_OP_JAL, 0, 0, 0);
      fetch_dec();
      push(0, 0, T_JAL, 0, 1);
`ifdef RV_MC_UPPER_IMM_EN
      ir(T_OP_LUI, 0, 0, 0);
      fetch_dec();
      push(0, 0, T_UPPER, 0, 0, 0, 2'd2);
      push(0, 0, T_ALUWB);
      ir(T_OP_AUIPC, 0, 0, 0);
      fetch_dec();
      push(0, 0, T_UPPER, 0, 0, 0, 2'd1);
      push(0, 0, T_ALUWB);
`else
      ir(T_OP_LUI, 0, 0, 0);
      fetch_dec();
      push(0, 0, T_TRAP, 0, 0, 0, 0, 0, 2'd1);
      push(0, 1, T_TRAP, 0, 0, 0, 0, 0, 2'd1);
      push(1, 0, T_RST);
`endif
      // reserved branch funct3 traps as illegal after the BRANCH cycle
      br(3'b010, 3'b100, 0);
      push(0, 0, T_TRAP, 0, 0, 0, 0, 0, 2'd1);
      push(1, 0, T_RST);
      // mem_ready arriving in the last allowed wait cycle wins
      ir(T_OP_I, 0, 0, 0);
      for (int i = 0; i < 15; i++) push(0, 0, T_FETCH);
      fetch_dec();
      push(0, 0, T_EXECI, 0, 0, 4'd0);
      push(0, 0, T_ALUWB);
      // reset during a MEMWR wait, then a full fetch timeout from a cleared counter
      ir(T_OP_STORE, 3'b010, 0, 0);
      fetch_dec();
      push(0, 0, T_MEMADR, 0, 0, 0, 0, 3'd1);
      push(0, 0, T_MEMWR);
      push(0, 0, T_MEMWR);
      push(1, 0, T_RST);
      for (int i = 0; i < 16; i++) push(0, 0, T_FETCH);
      push(0, 0, T_TRAP, 0, 0, 0, 0, 0, 2'd2);
      push(0, 1, T_TRAP, 0, 0, 0, 0, 0, 2'd2);
      push(1, 0, T_RST);
      // illegal opcode
      ir(7'b0000000, 0, 0, 0);
      fetch_dec();
      push(0, 0, T_TRAP, 0, 0, 0, 0, 0, 2'd1);
      push(1, 0, T_RST);
      push(0, 0, T_FETCH);
   endtask

   initial begin
      out_t act, exp_o, care;
      fill();
      for (int i = 0; i < rows.size(); i++) begin
         @(negedge clk);
         rst = rows[i].rst; op = rows[i].op; funct3 = rows[i].f3; funct7b5 = rows[i].f7;
         {zero, lt, ltu} = rows[i].flags; mem_ready = rows[i].rdy;
         #1;
         act = '{mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, fault,
                 fault_code, alu_src_a, alu_src_b, imm_src, result_src, alu_control};
         expect_of(rows[i], exp_o, care);
         check($sformatf("row%0d_%s", i, rows[i].st.name()), act, exp_o, care);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
